dpram_fifo_ctrl: RTL
====================

# dpram_fifo_ctrl

Synchronous FIFO controller that owns both ports of the 8x16 asynchronous dual-port RAM: port A is the write side, port B the read side. It turns a valid/ready push stream into registered RAM write strobes and presents the RAM read data as a first-word-fall-through valid/ready pop stream. It is the stage directly upstream of the RAM; the RAM holds no state other than its array.

## Interface
Parameters:
- DATA_W, 16, word width; must match RAM.
- ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W = 8.
- AFULL_LVL, 6, occupancy at or above which afull asserts (1..DEPTH).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  push request.
- wr_ready  out  1  push accepted when wr_valid && wr_ready.
- wr_data  in  DATA_W  push word.
- rd_valid  out  1  rd_data holds the head word.
- rd_ready  in  1  pop when rd_valid && rd_ready.
- rd_data  out  DATA_W  head word (RAM port B data, passed through).
- level  out  ADDR_W+1  committed occupancy, 0..DEPTH.
- afull  out  1  level + pending >= AFULL_LVL.
- ram_we_a  out  1  RAM port A write enable, registered.
- ram_addr_a  out  ADDR_W  RAM port A address, registered.
- ram_din_a  out  DATA_W  RAM port A data, registered.
- ram_addr_b  out  ADDR_W  RAM port B address = rd_ptr.
- ram_dout_b  in  DATA_W  RAM port B read data.

## Operation
- State: wr_ptr, rd_ptr (ADDR_W, wrap 7->0), level (0..8), pending (1 bit: write staged in port A registers).
- Push cycle N: ram_addr_a<=wr_ptr, ram_din_a<=wr_data, ram_we_a<=1, pending<=1, wr_ptr++ at edge ending N.
- Commit cycle N+1: ram_we_a high the whole cycle; at edge ending N+1, level++ and pending clears unless a new push was accepted in N+1 (back-to-back pushes keep ram_we_a high with new addr/data).
- ram_we_a low in every cycle with no staged write; addr_a/din_a hold last value.
- wr_ready = (level + pending) < DEPTH. No bypass: push while full is refused even if pop in the same cycle.
- rd_valid = (level != 0); rd_data = ram_dout_b; ram_addr_b = rd_ptr.
- Pop: rd_ptr++, level-- at edge. Commit and pop in same cycle: level unchanged.
- Pop of a word never overlaps its own commit (it is not counted in level until committed).
- Push without wr_ready, pop without rd_valid: ignored, no state change.

## Timing
- Reset (async assert, sync deassert by system): wr_ptr=rd_ptr=0, level=0, pending=0, ram_we_a=0, ram_addr_a=0, ram_din_a=0, wr_ready=1, rd_valid=0, afull=0 (AFULL_LVL>=1). RAM contents undefined and not cleared.
- Reset mid-write: staged write is dropped, ram_we_a falls immediately.
- Push-to-rd_valid latency: 2 cycles (push edge N, commit edge N+1, rd_valid in N+2) when empty.
- Pop-to-next-head: 1 cycle (rd_ptr advance, RAM read async).
- Sustained throughput: 1 push and 1 pop per cycle.

## Configuration
- DPRAM_FIFO_ERR_EN defined: adds outputs ovf and udf (1 bit each, reset 0), sticky until reset; ovf sets on wr_valid && !wr_ready, udf on rd_ready && !rd_valid.
- Undefined: ports absent, no error logic; behaviour otherwise identical.

## Structure
- Package dpram_pkg: DATA_W, ADDR_W, DEPTH constants and a level typedef of width ADDR_W+1, shared with the RAM wrapper.
- One sub-module, dpram_wrap_ptr: ADDR_W-bit pointer with increment enable and async active-low reset; instanced for wr_ptr and rd_ptr.

## Test plan
- Reset, push 0x1111 with rd_ready=0 -> ram_we_a=1 addr 0 next cycle, rd_valid=1 and rd_data=0x1111 two cycles after push, level=1.
- Push 8 words 0x0000..0x0007 back-to-back -> ram_we_a high 8 consecutive cycles, wr_ready=0 once level+pending=8, afull from 6th accepted push; extra push refused.
- Full, then pop all 8 with rd_ready=1 -> data 0x0000..0x0007 in order, rd_valid falls after 8th, level=0, pointers wrapped to 0.
- Steady stream push+pop every cycle for 20 words across wrap -> level holds 1, order preserved, no drops.
- Assert rst_n low during commit cycle of a push -> ram_we_a drops at once, level=0, rd_valid=0 after release.
- With DPRAM_FIFO_ERR_EN: pop when empty -> udf=1; push when full -> ovf=1; both held until reset.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants for the 8x16 dual-port RAM and its FIFO controller.
// The RAM wrapper and the controller both take their default geometry
// from here so that word width and address width cannot drift apart.
package dpram_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  // Occupancy needs one extra bit so that "full" (DEPTH) is representable.
  typedef logic [ADDR_W:0] level_t;

endpackage : dpram_pkg

// File: rtl/dpram_wrap_ptr.sv
// Wrapping RAM address pointer: counts up by one when inc is high and
// wraps naturally from 2**ADDR_W-1 back to 0. Used for both the write
// and the read pointer of the FIFO controller.
module dpram_wrap_ptr #(
  parameter int ADDR_W = dpram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // Pointer register; power-of-two depth makes the wrap a plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values and simulation order between blocks cannot matter.
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

endmodule : dpram_wrap_ptr

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller owning both ports of an asynchronous dual-port RAM.
// Port A (write) is driven from registers: an accepted push is staged in
// ram_addr_a/ram_din_a with ram_we_a high for the following cycle, and is
// counted in level only once that write cycle ends. Port B (read) is
// addressed by rd_ptr and its data is presented directly as a
// first-word-fall-through pop stream.
//
// Optional feature: define DPRAM_FIFO_ERR_EN to add sticky ovf/udf flags
// (push refused while full / pop attempted while empty).
module dpram_fifo_ctrl #(
  parameter int DATA_W    = dpram_pkg::DATA_W,
  parameter int ADDR_W    = dpram_pkg::ADDR_W,
  parameter int AFULL_LVL = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  // push stream
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  // pop stream
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  // status
  output logic [ADDR_W:0]   level,
  output logic              afull,
  // RAM port A (write)
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  // RAM port B (read)
  output logic [ADDR_W-1:0] ram_addr_b,
  input  logic [DATA_W-1:0] ram_dout_b
`ifdef DPRAM_FIFO_ERR_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  // Occupancy thresholds at the width of the level+pending sum.
  localparam logic [ADDR_W+1:0] DEPTH_OCC = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W+1:0] AFULL_OCC = (ADDR_W+2)'(AFULL_LVL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic              pending_q;
  logic [ADDR_W+1:0] occ;
  logic              push;
  logic              pop;

  // Handshake decode. The staged write already owns a slot, so it counts
  // against free space; a pop in the same cycle never frees room for a
  // push (no bypass).
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    occ      = '0;
    wr_ready = 1'b0;
    rd_valid = 1'b0;
    afull    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;

    occ      = {1'b0, level_q} + {{(ADDR_W+1){1'b0}}, pending_q};
    wr_ready = (occ < DEPTH_OCC);
    rd_valid = (level_q != '0);
    afull    = (occ >= AFULL_OCC);
    push     = wr_valid && wr_ready;
    pop      = rd_ready && rd_valid;
  end

  assign level      = level_q;
  assign rd_data    = ram_dout_b;
  assign ram_addr_b = rd_ptr;
  // The staged-write flag is itself the registered RAM write strobe.
  assign ram_we_a   = pending_q;

  dpram_wrap_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  dpram_wrap_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Port A staging: load address/data on an accepted push; the strobe
  // stays high across back-to-back pushes and drops when nothing is staged.
  // Address and data simply hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= 1'b0;
      ram_addr_a <= '0;
      ram_din_a  <= '0;
    end else begin
      pending_q <= push;
      if (push) begin
        ram_addr_a <= wr_ptr;
        ram_din_a  <= wr_data;
      end
    end
  end

  // Committed occupancy: a staged write counts once its RAM write cycle
  // ends; a pop removes one. Both together leave level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_q + (ADDR_W+1)'(pending_q) - (ADDR_W+1)'(pop);
    end
  end

`ifdef DPRAM_FIFO_ERR_EN
  // Sticky protocol-error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_valid && !wr_ready) ovf <= 1'b1;
      if (rd_ready && !rd_valid) udf <= 1'b1;
    end
  end
`endif

endmodule : dpram_fifo_ctrl
